// File: rtl/interp_sample_window.sv
// ============================================================================
// Module   : interp_sample_window
// Purpose  : Sliding window of the DEPTH most recent samples feeding the
//            A/B/C interpolation coefficient stage. Index 0 is the newest.
//            Optional macro INTERP_WIN_STATS_EN adds a consumed-window counter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module interp_sample_window #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [WIDTH-1:0]                in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            flush,
    output logic [DEPTH-1:0][WIDTH-1:0]     data_buffer,
    output logic                            win_valid,
    input  logic                            win_ready,
    output logic [3:0]                      fill_count
`ifdef INTERP_WIN_STATS_EN
    ,
    output logic [15:0]                     win_count
`endif
);

    typedef enum logic [1:0] {
        S_FILL       = 2'd0,
        S_FULL_IDLE  = 2'd1,
        S_FULL_VALID = 2'd2
    } state_t;

    localparam logic [3:0] c_depth = 4'(DEPTH);

    state_t                         r_state;
    state_t                         w_state_next;
    logic [DEPTH-1:0][WIDTH-1:0]    r_buf;
    logic [3:0]                     r_count;
    logic [3:0]                     w_count_next;
    logic                           r_win_valid;
    logic                           w_win_valid_next;
    logic                           w_in_ready;
    logic                           w_accept;
    logic                           w_shift;
    logic                           w_clear;

    // A full window blocks new input until downstream takes it.
    assign w_in_ready = !flush && (!r_win_valid || win_ready);
    assign w_accept   = in_valid && w_in_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_FILL;
            r_count     <= 4'd0;
            r_win_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_count     <= w_count_next;
            r_win_valid <= w_win_valid_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_count_next     = r_count;
        w_win_valid_next = r_win_valid;
        w_shift          = 1'b0;
        w_clear          = 1'b0;
        if (flush) begin
            w_clear          = 1'b1;
            w_state_next     = S_FILL;
            w_count_next     = 4'd0;
            w_win_valid_next = 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        w_shift = 1'b1;
                        if (r_count >= c_depth - 4'd1) begin
                            w_count_next     = c_depth;
                            w_state_next     = S_FULL_VALID;
                            w_win_valid_next = 1'b1;
                        end else begin
                            w_count_next = r_count + 4'd1;
                        end
                    end
                end
                S_FULL_IDLE: begin
                    if (w_accept) begin
                        w_shift          = 1'b1;
                        w_state_next     = S_FULL_VALID;
                        w_win_valid_next = 1'b1;
                    end
                end
                S_FULL_VALID: begin
                    if (win_ready) begin
                        if (w_accept) begin
                            w_shift = 1'b1;
                        end else begin
                            w_state_next     = S_FULL_IDLE;
                            w_win_valid_next = 1'b0;
                        end
                    end
                end
                default: begin
                    w_state_next     = S_FILL;
                    w_count_next     = 4'd0;
                    w_win_valid_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_buf <= '0;
        end else if (w_clear) begin
            r_buf <= '0;
        end else if (w_shift) begin
            r_buf <= {r_buf[DEPTH-2:0], in_data};
        end
    end

`ifdef INTERP_WIN_STATS_EN
    logic [15:0] r_win_count;

    // Counts consumed windows; survives flush, wraps naturally at 16 bits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_win_count <= 16'd0;
        end else if (r_win_valid && win_ready) begin
            r_win_count <= r_win_count + 16'd1;
        end
    end

    assign win_count = r_win_count;
`endif

    assign in_ready    = w_in_ready;
    assign data_buffer = r_buf;
    assign win_valid   = r_win_valid;
    assign fill_count  = r_count;

endmodule

`default_nettype wire
